// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM transaction controller.
// State encoding, datapath widths and default lock threshold.
package cajero_pkg;

  localparam int BALANCE_W        = 64;
  localparam int MONTO_W          = 32;
  localparam int PIN_DIGITS       = 4;
  localparam int PIN_W            = 4 * PIN_DIGITS;
  localparam int MAX_INTENTOS_DEF = 3;

  localparam logic [1:0] ST_ESPERA_TARJETA = 2'd0;
  localparam logic [1:0] ST_INGRESO_PIN    = 2'd1;
  localparam logic [1:0] ST_ESPERA_MONTO   = 2'd2;
  localparam logic [1:0] ST_BLOQUEADO      = 2'd3;

  typedef logic [BALANCE_W-1:0] balance_t;

endpackage

// File: rtl/cajero_pin_entry.sv
// PIN keypad collector: shifts digits in MSB-first and flags
// the final digit together with the equality result.
module cajero_pin_entry
  import cajero_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stb,
  input  logic [3:0]       digit,
  input  logic [PIN_W-1:0] pin,
  output logic             done,
  output logic             match
);

  localparam int CNT_W = $clog2(PIN_DIGITS);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PIN_W-5:0] shift_q, shift_d;
  logic [PIN_W-1:0] entry;

  always_comb begin
    entry   = {shift_q, digit};
    done    = en & stb & (count_q == CNT_W'(PIN_DIGITS - 1));
    match   = (entry == pin);
    shift_d = shift_q;
    count_d = count_q;
    // Leaving the entry phase always discards partial input
    if (!en) begin
      shift_d = '0;
      count_d = '0;
    end else if (stb) begin
      shift_d = entry[PIN_W-5:0];
      count_d = done ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      shift_q <= '0;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/cajero_fsm.sv
// ATM transaction controller: card detect, PIN check with
// lockout, and a single deposit/withdrawal per card insertion.
module cajero_fsm
  import cajero_pkg::*;
#(
  parameter balance_t BALANCE_INICIAL = 64'd1000,
  parameter int       MAX_INTENTOS    = MAX_INTENTOS_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               TARJETA_RECIBIDA,
  input  logic               TIPO_TRANS,
  input  logic               DIGITO_STB,
  input  logic [3:0]         DIGITO,
  input  logic [PIN_W-1:0]   PIN,
  input  logic               MONTO_STB,
  input  logic [MONTO_W-1:0] MONTO,
  output logic               BALANCE_ACTUALIZADO,
  output logic               ENTREGAR_DINERO,
  output logic               FONDOS_INSUFICIENTES,
  output logic               PIN_INCORRECTO,
  output logic               BLOQUEO,
  output logic [1:0]         ADVERTENCIA
);

  localparam logic [1:0] ATT_LAST = 2'(MAX_INTENTOS - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] att_q, att_d;
  logic       card_q;
  balance_t   bal_q, bal_d;
  balance_t   monto_ext;
  logic       act_q, act_d;
  logic       ent_q, ent_d;
  logic       fon_q, fon_d;
  logic       bad_q, bad_d;
  logic       bloq_q, bloq_d;
  logic       pin_en, pin_done, pin_match;

  assign pin_en = (state_q == ST_INGRESO_PIN) & TARJETA_RECIBIDA;

  cajero_pin_entry u_pin (
    .clk   (CLK),
    .rst   (RESET),
    .en    (pin_en),
    .stb   (DIGITO_STB),
    .digit (DIGITO),
    .pin   (PIN),
    .done  (pin_done),
    .match (pin_match)
  );

  always_comb begin
    monto_ext = {{(BALANCE_W - MONTO_W){1'b0}}, MONTO};
    state_d   = state_q;
    att_d     = att_q;
    bal_d     = bal_q;
    act_d     = 1'b0;
    ent_d     = 1'b0;
    fon_d     = 1'b0;
    bad_d     = 1'b0;
    case (state_q)
      ST_ESPERA_TARJETA: begin
        if (TARJETA_RECIBIDA && !card_q)
          state_d = ST_INGRESO_PIN;
      end
      ST_INGRESO_PIN: begin
        if (!TARJETA_RECIBIDA) begin
          state_d = ST_ESPERA_TARJETA;
        end else if (pin_done) begin
          if (pin_match) begin
            state_d = ST_ESPERA_MONTO;
            att_d   = '0;
          end else begin
            bad_d = 1'b1;
            // Count saturates at the last value so the warning holds
            if (att_q == ATT_LAST)
              state_d = ST_BLOQUEADO;
            else
              att_d = att_q + 2'd1;
          end
        end
      end
      ST_ESPERA_MONTO: begin
        if (!TARJETA_RECIBIDA) begin
          state_d = ST_ESPERA_TARJETA;
        end else if (MONTO_STB) begin
          state_d = ST_ESPERA_TARJETA;
          if (!TIPO_TRANS) begin
            bal_d = bal_q + monto_ext;
            act_d = 1'b1;
          end else if (monto_ext <= bal_q) begin
            bal_d = bal_q - monto_ext;
            act_d = 1'b1;
            ent_d = 1'b1;
          end else begin
            fon_d = 1'b1;
          end
        end
      end
      ST_BLOQUEADO: begin
      end
      default: state_d = ST_ESPERA_TARJETA;
    endcase
    bloq_d = (state_d == ST_BLOQUEADO);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_ESPERA_TARJETA;
      att_q   <= '0;
      card_q  <= 1'b0;
      bal_q   <= BALANCE_INICIAL;
      act_q   <= 1'b0;
      ent_q   <= 1'b0;
      fon_q   <= 1'b0;
      bad_q   <= 1'b0;
      bloq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      att_q   <= att_d;
      card_q  <= TARJETA_RECIBIDA;
      bal_q   <= bal_d;
      act_q   <= act_d;
      ent_q   <= ent_d;
      fon_q   <= fon_d;
      bad_q   <= bad_d;
      bloq_q  <= bloq_d;
    end
  end

  assign BALANCE_ACTUALIZADO  = act_q;
  assign ENTREGAR_DINERO      = ent_q;
  assign FONDOS_INSUFICIENTES = fon_q;
  assign PIN_INCORRECTO       = bad_q;
  assign BLOQUEO              = bloq_q;
  assign ADVERTENCIA          = att_q;

endmodule

// File: tb/tb_cajero_fsm.sv
// Self-checking bench for cajero_fsm: directed sessions then
// randomized traffic against a session-level reference model.
module tb_cajero_fsm;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TARJETA_RECIBIDA;
  logic        TIPO_TRANS;
  logic        DIGITO_STB;
  logic [3:0]  DIGITO;
  logic [15:0] PIN;
  logic        MONTO_STB;
  logic [31:0] MONTO;
  logic        BALANCE_ACTUALIZADO;
  logic        ENTREGAR_DINERO;
  logic        FONDOS_INSUFICIENTES;
  logic        PIN_INCORRECTO;
  logic        BLOQUEO;
  logic [1:0]  ADVERTENCIA;

  always #5 CLK = ~CLK;

  cajero_fsm dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .TARJETA_RECIBIDA     (TARJETA_RECIBIDA),
    .TIPO_TRANS           (TIPO_TRANS),
    .DIGITO_STB           (DIGITO_STB),
    .DIGITO               (DIGITO),
    .PIN                  (PIN),
    .MONTO_STB            (MONTO_STB),
    .MONTO                (MONTO),
    .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
    .ENTREGAR_DINERO      (ENTREGAR_DINERO),
    .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES),
    .PIN_INCORRECTO       (PIN_INCORRECTO),
    .BLOQUEO              (BLOQUEO),
    .ADVERTENCIA          (ADVERTENCIA)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Session-level reference model
  longint unsigned m_bal;
  int              m_att;
  bit              m_locked, m_active, m_pin_ok, m_prev;
  int              m_digits[$];
  bit              e_act, e_ent, e_fon, e_bad;

  function automatic void model_reset();
    m_bal    = 1000;
    m_att    = 0;
    m_locked = 0;
    m_active = 0;
    m_pin_ok = 0;
    m_prev   = 0;
    m_digits.delete();
    e_act = 0; e_ent = 0; e_fon = 0; e_bad = 0;
  endfunction

  function automatic void model_step();
    int entered;
    longint unsigned amt;
    e_act = 0; e_ent = 0; e_fon = 0; e_bad = 0;
    if (!m_locked) begin
      if (!m_active) begin
        if (TARJETA_RECIBIDA && !m_prev) begin
          m_active = 1;
          m_pin_ok = 0;
          m_digits.delete();
        end
      end else if (!TARJETA_RECIBIDA) begin
        m_active = 0;
        m_digits.delete();
      end else if (!m_pin_ok) begin
        if (DIGITO_STB) begin
          m_digits.push_back(int'(DIGITO));
          if (m_digits.size() == 4) begin
            entered = 0;
            foreach (m_digits[i]) entered = entered * 16 + m_digits[i];
            if (entered == int'(PIN)) begin
              m_pin_ok = 1;
              m_att = 0;
            end else begin
              e_bad = 1;
              m_att++;
              if (m_att >= 3) m_locked = 1;
            end
            m_digits.delete();
          end
        end
      end else if (MONTO_STB) begin
        amt = longint'(MONTO);
        if (!TIPO_TRANS) begin
          m_bal += amt;
          e_act = 1;
        end else if (amt <= m_bal) begin
          m_bal -= amt;
          e_act = 1;
          e_ent = 1;
        end else begin
          e_fon = 1;
        end
        m_active = 0;
      end
    end
    m_prev = TARJETA_RECIBIDA;
  endfunction

  task automatic compare_outputs();
    check("BALANCE_ACTUALIZADO", BALANCE_ACTUALIZADO, e_act);
    check("ENTREGAR_DINERO", ENTREGAR_DINERO, e_ent);
    check("FONDOS_INSUFICIENTES", FONDOS_INSUFICIENTES, e_fon);
    check("PIN_INCORRECTO", PIN_INCORRECTO, e_bad);
    check("BLOQUEO", BLOQUEO, m_locked);
    check("ADVERTENCIA", ADVERTENCIA, m_locked ? 2 : m_att);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic step(input bit card, input bit dstb = 0,
                      input logic [3:0] dig = 0, input bit mstb = 0,
                      input bit tipo = 0, input logic [31:0] monto = 0);
    TARJETA_RECIBIDA = card;
    DIGITO_STB = dstb;
    DIGITO = dig;
    MONTO_STB = mstb;
    TIPO_TRANS = tipo;
    MONTO = monto;
    cycle();
    DIGITO_STB = 0;
    MONTO_STB = 0;
  endtask

  task automatic do_reset();
    TARJETA_RECIBIDA = 0;
    DIGITO_STB = 0;
    MONTO_STB = 0;
    RESET = 1;
    #2;
    model_reset();
    compare_outputs();
    @(posedge CLK);
    #1;
    RESET = 0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) step(1, 1, p[15-4*i -: 4]);
  endtask

  task automatic session(input bit tipo, input logic [31:0] monto);
    step(1);
    enter_pin(16'h1234);
    step(1, 0, 0, 1, tipo, monto);
  endtask

  initial begin
    bit c, ds, ms, tp;
    logic [3:0] dg;
    logic [31:0] mo;
    int idx;
    TIPO_TRANS = 0; DIGITO = 0; MONTO = 0;
    PIN = 16'h1234;
    do_reset();
    check("rst_adv", ADVERTENCIA, 0);

    step(0);
    session(0, 500);
    check("dep_act", BALANCE_ACTUALIZADO, 1);
    check("dep_ent", ENTREGAR_DINERO, 0);
    step(1);
    check("dep_one_cycle", BALANCE_ACTUALIZADO, 0);
    step(1); step(1, 1, 1); step(1, 0, 0, 1, 0, 9);
    check("held_card_idle", BALANCE_ACTUALIZADO, 0);

    step(0);
    session(1, 300);
    check("wd300_ent", ENTREGAR_DINERO, 1);
    step(0);
    session(1, 1200);
    check("wd_all_ent", ENTREGAR_DINERO, 1);
    step(0);
    session(1, 1);
    check("wd_empty_fon", FONDOS_INSUFICIENTES, 1);

    do_reset();
    step(0);
    session(1, 5000);
    check("wd5000_fon", FONDOS_INSUFICIENTES, 1);
    check("wd5000_act", BALANCE_ACTUALIZADO, 0);
    step(0);
    session(1, 1000);
    check("wd1000_ent", ENTREGAR_DINERO, 1);

    step(0); step(1);
    enter_pin(16'h1235);
    check("bad1", PIN_INCORRECTO, 1);
    check("adv1", ADVERTENCIA, 1);
    enter_pin(16'h1235);
    check("adv2", ADVERTENCIA, 2);
    enter_pin(16'h1235);
    check("bad3", PIN_INCORRECTO, 1);
    check("lock", BLOQUEO, 1);
    enter_pin(16'h1234);
    step(1, 0, 0, 1, 0, 500);
    check("locked_no_act", BALANCE_ACTUALIZADO, 0);
    step(0); step(1);
    check("locked_hold", BLOQUEO, 1);

    do_reset();
    step(1); step(1, 1, 1); step(1, 1, 2);
    do_reset();
    step(0);
    session(0, 10);
    check("after_midpin_rst", BALANCE_ACTUALIZADO, 1);

    step(0); step(1); step(1, 1, 1); step(1, 1, 2);
    step(0);
    check("removal_no_pulse", PIN_INCORRECTO, 0);
    step(1);
    enter_pin(16'h1234);
    step(1, 0, 0, 1, 0, 7);
    check("reinsert_act", BALANCE_ACTUALIZADO, 1);

    step(0); step(1);
    enter_pin(16'h1234);
    step(0, 0, 0, 1, 1, 1);
    check("removal_wins", ENTREGAR_DINERO, 0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0 ||
          (m_locked && $urandom_range(0, 19) == 0)) begin
        PIN = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        do_reset();
        continue;
      end
      c = TARJETA_RECIBIDA;
      if (c) c = ($urandom_range(0, 29) != 0);
      else   c = ($urandom_range(0, 4) == 0);
      ds = ($urandom_range(0, 2) == 0);
      idx = m_digits.size();
      if ($urandom_range(0, 5) == 0) dg = 4'($urandom);
      else dg = PIN[15-4*idx -: 4];
      ms = ($urandom_range(0, 4) == 0);
      tp = 1'($urandom);
      if ($urandom_range(0, 3) == 0) mo = $urandom;
      else mo = $urandom_range(0, 1500);
      step(c, ds, dg, ms, tp, mo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
